// File: rtl/window_gen3x3_pkg.sv
// Shared constants for the 3x3 window generator: kernel size, window slot
// indices (row-major, TL at slot 0) and a slice extractor for packed windows.
package win_pkg;

  localparam int KERNEL = 3;
  localparam int WIN_N  = KERNEL * KERNEL;

  localparam int TL = 0;
  localparam int TC = 1;
  localparam int TR = 2;
  localparam int ML = 3;
  localparam int MC = 4;
  localparam int MR = 5;
  localparam int BL = 6;
  localparam int BC = 7;
  localparam int BR = 8;

  // Widest sample the slice helper can return.
  localparam int SLICE_MAX_W = 32;

  // Extract slot k of a packed window whose samples are data_w bits wide.
  function automatic logic [SLICE_MAX_W-1:0] win_slice(
    input logic [WIN_N*SLICE_MAX_W-1:0] win,
    input int unsigned                  data_w,
    input int unsigned                  k
  );
    logic [WIN_N*SLICE_MAX_W-1:0] shifted;
    logic [SLICE_MAX_W-1:0]       mask;
    mask    = '1;
    mask    = mask >> (SLICE_MAX_W - data_w);
    shifted = win >> (k * data_w);
    return shifted[SLICE_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/window_gen3x3_if.sv
// Pixel-in / window-out bundle of the 3x3 window generator.
// master = stream source and window consumer, slave = the generator.
interface window_gen3x3_if
  import win_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MAX_WIDTH  = 128,
  parameter int MAX_HEIGHT = 128
);
  localparam int CW = $clog2(MAX_WIDTH + 1);
  localparam int RW = $clog2(MAX_HEIGHT + 1);

  logic                    sof;
  logic                    in_valid;
  logic [DATA_W-1:0]       pixel_in;
  logic [CW-1:0]           stage_width;
  logic [RW-1:0]           stage_height;
  logic                    stride2;

  logic                    win_valid;
  logic [WIN_N*DATA_W-1:0] win_data;
  logic                    win_eol;
  logic                    win_eof;
  logic                    cfg_err;

  modport master (
    output sof, in_valid, pixel_in, stage_width, stage_height, stride2,
    input  win_valid, win_data, win_eol, win_eof, cfg_err
  );

  modport slave (
    input  sof, in_valid, pixel_in, stage_width, stage_height, stride2,
    output win_valid, win_data, win_eol, win_eof, cfg_err
  );

endinterface

// File: rtl/window_gen3x3_line_buffer.sv
// One circular row buffer: combinational read at ptr, write of din at the
// same ptr on en, so dout is the sample stored one row earlier at this column.
module line_buffer #(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 128,
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [PW-1:0]     ptr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign dout = mem_q[ptr];

  // Storage: cleared on reset, written in place when a pixel is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (en) begin
      mem_q[ptr] <= din;
    end
  end

endmodule

// File: rtl/window_gen3x3.sv
// 3x3 sliding-window generator over a raster pixel stream with stride 1/2,
// per-frame dimension capture, end-of-row/frame markers and config error flag.
module window_gen3x3
  import win_pkg::*;
#(
  parameter int  DATA_W     = 8,
  parameter int  MAX_WIDTH  = 128,
  parameter int  MAX_HEIGHT = 128,
  localparam int CW         = $clog2(MAX_WIDTH + 1),
  localparam int RW         = $clog2(MAX_HEIGHT + 1),
  localparam int PW         = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  window_gen3x3_if.slave bus
);

  // Frame configuration and raster position.
  logic [CW-1:0] width_q,  width_d;
  logic [RW-1:0] height_q, height_d;
  logic          stride2_q, stride2_d;
  logic          active_q,  active_d;
  logic          cfg_err_q, cfg_err_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Two most recent columns of the window (row 0 = oldest line).
  logic [DATA_W-1:0] tap_q [KERNEL][KERNEL-1];
  logic [DATA_W-1:0] tap_d [KERNEL][KERNEL-1];

  // Registered window outputs.
  logic                    win_valid_q, win_valid_d;
  logic                    win_eol_q,   win_eol_d;
  logic                    win_eof_q,   win_eof_d;
  logic [WIN_N*DATA_W-1:0] win_data_q,  win_data_d;

  // Per-cycle view of the incoming pixel.
  logic                    legal, start, accept, eligible;
  logic [CW-1:0]           width_eff, col_pos, last_col, elig_col;
  logic [RW-1:0]           height_eff, row_pos, last_row, elig_row;
  logic                    stride_eff, col_end, row_end;
  logic [DATA_W-1:0]       lb1_dout, lb2_dout;
  logic [DATA_W-1:0]       new_col [KERNEL];
  logic [WIN_N*DATA_W-1:0] win_now;

  // LB1 holds the previous row; LB2 receives what LB1 drops (row before that).
  line_buffer #(.DATA_W(DATA_W), .DEPTH(MAX_WIDTH)) u_lb1 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (accept),
    .ptr  (col_pos[PW-1:0]),
    .din  (bus.pixel_in),
    .dout (lb1_dout)
  );

  line_buffer #(.DATA_W(DATA_W), .DEPTH(MAX_WIDTH)) u_lb2 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (accept),
    .ptr  (col_pos[PW-1:0]),
    .din  (lb1_dout),
    .dout (lb2_dout)
  );

  // Acceptance, position, eligibility and the candidate window for this pixel.
  always_comb begin
    legal = (bus.stage_width  >= CW'(KERNEL)) && (bus.stage_width  <= CW'(MAX_WIDTH)) &&
            (bus.stage_height >= RW'(KERNEL)) && (bus.stage_height <= RW'(MAX_HEIGHT));
    start  = bus.in_valid && bus.sof;
    accept = bus.in_valid && (bus.sof ? legal : active_q);

    // A sof pixel is evaluated against the configuration it brings along.
    width_eff  = bus.sof ? bus.stage_width  : width_q;
    height_eff = bus.sof ? bus.stage_height : height_q;
    stride_eff = bus.sof ? bus.stride2      : stride2_q;
    col_pos    = bus.sof ? '0 : col_q;
    row_pos    = bus.sof ? '0 : row_q;

    last_col = width_eff  - CW'(1);
    last_row = height_eff - RW'(1);
    // With stride 2 the last window sits on the last even index.
    elig_col = (stride_eff && last_col[0]) ? last_col - CW'(1) : last_col;
    elig_row = (stride_eff && last_row[0]) ? last_row - RW'(1) : last_row;
    col_end  = (col_pos == last_col);
    row_end  = (row_pos == last_row);

    eligible = (row_pos >= RW'(2)) && (col_pos >= CW'(2)) &&
               (!stride_eff || (!row_pos[0] && !col_pos[0]));

    new_col[0] = lb2_dout;
    new_col[1] = lb1_dout;
    new_col[2] = bus.pixel_in;

    win_now = '0;
    win_now[TL*DATA_W +: DATA_W] = tap_q[0][0];
    win_now[TC*DATA_W +: DATA_W] = tap_q[0][1];
    win_now[TR*DATA_W +: DATA_W] = new_col[0];
    win_now[ML*DATA_W +: DATA_W] = tap_q[1][0];
    win_now[MC*DATA_W +: DATA_W] = tap_q[1][1];
    win_now[MR*DATA_W +: DATA_W] = new_col[1];
    win_now[BL*DATA_W +: DATA_W] = tap_q[2][0];
    win_now[BC*DATA_W +: DATA_W] = tap_q[2][1];
    win_now[BR*DATA_W +: DATA_W] = new_col[2];
  end

  // Next state: config capture on sof, raster advance and window emission.
  always_comb begin
    width_d     = width_q;
    height_d    = height_q;
    stride2_d   = stride2_q;
    active_d    = active_q;
    cfg_err_d   = cfg_err_q;
    col_d       = col_q;
    row_d       = row_q;
    tap_d       = tap_q;
    win_valid_d = 1'b0;
    win_eol_d   = 1'b0;
    win_eof_d   = 1'b0;
    win_data_d  = win_data_q;

    if (start) begin
      cfg_err_d = !legal;
      active_d  = legal;
      if (legal) begin
        width_d   = bus.stage_width;
        height_d  = bus.stage_height;
        stride2_d = bus.stride2;
      end
    end

    if (accept) begin
      for (int r = 0; r < KERNEL; r++) begin
        tap_d[r][0] = tap_q[r][1];
        tap_d[r][1] = new_col[r];
      end

      if (col_end && row_end) begin
        col_d    = '0;
        row_d    = '0;
        active_d = 1'b0;
      end else if (col_end) begin
        col_d = '0;
        row_d = row_pos + RW'(1);
      end else begin
        col_d = col_pos + CW'(1);
        row_d = row_pos;
      end

      if (eligible) begin
        win_valid_d = 1'b1;
        win_data_d  = win_now;
        win_eol_d   = (col_pos == elig_col);
        win_eof_d   = (col_pos == elig_col) && (row_pos == elig_row);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q     <= '0;
      height_q    <= '0;
      stride2_q   <= 1'b0;
      active_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_eol_q   <= 1'b0;
      win_eof_q   <= 1'b0;
      win_data_q  <= '0;
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL - 1; c++) begin
          tap_q[r][c] <= '0;
        end
      end
    end else begin
      width_q     <= width_d;
      height_q    <= height_d;
      stride2_q   <= stride2_d;
      active_q    <= active_d;
      cfg_err_q   <= cfg_err_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_eol_q   <= win_eol_d;
      win_eof_q   <= win_eof_d;
      win_data_q  <= win_data_d;
      tap_q       <= tap_d;
    end
  end

  assign bus.win_valid = win_valid_q;
  assign bus.win_data  = win_data_q;
  assign bus.win_eol   = win_eol_q;
  assign bus.win_eof   = win_eof_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_window_gen3x3.sv
// Bench for window_gen3x3: a frame-image reference model predicts every
// output on every cycle; directed frames add count/value checks.
module tb_window_gen3x3;
  import win_pkg::*;

  localparam int DW = 8;
  localparam int MW = 128;
  localparam int MH = 128;

  logic clk;
  logic rst_n;

  window_gen3x3_if #(.DATA_W(DW), .MAX_WIDTH(MW), .MAX_HEIGHT(MH)) bus ();

  window_gen3x3 #(.DATA_W(DW), .MAX_WIDTH(MW), .MAX_HEIGHT(MH)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the frame as a 2-D image plus the raster position.
  logic [DW-1:0]      img [MH][MW];
  bit                 m_act, m_err, m_S, m_vld, m_eol, m_eof;
  int                 m_W, m_H, m_r, m_c;
  logic [9*DW-1:0]    m_data;

  // Drive values for the configuration inputs.
  int cur_w, cur_h;
  bit cur_s;

  // Observed window history for directed checks.
  logic [9*DW-1:0] win_q[$];
  int              nwin;
  logic [15:0]     eol_h, eof_h;

  task automatic model_reset();
    m_act = 0; m_err = 0; m_S = 0; m_vld = 0; m_eol = 0; m_eof = 0;
    m_W = 0; m_H = 0; m_r = 0; m_c = 0; m_data = '0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic [DW-1:0] p);
    int lc, lr;
    m_vld = 0; m_eol = 0; m_eof = 0;
    if (!v) return;
    if (s) begin
      if (cur_w < 3 || cur_w > MW || cur_h < 3 || cur_h > MH) begin
        m_err = 1; m_act = 0;
        return;
      end
      m_err = 0; m_act = 1; m_W = cur_w; m_H = cur_h; m_S = cur_s; m_r = 0; m_c = 0;
    end
    if (!m_act) return;
    img[m_r][m_c] = p;
    if (m_r >= 2 && m_c >= 2 && (!m_S || (m_r % 2 == 0 && m_c % 2 == 0))) begin
      m_vld = 1;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          m_data[(i*3+j)*DW +: DW] = img[m_r-2+i][m_c-2+j];
      lc = m_S ? ((m_W - 1) / 2) * 2 : m_W - 1;
      lr = m_S ? ((m_H - 1) / 2) * 2 : m_H - 1;
      m_eol = (m_c == lc);
      m_eof = m_eol && (m_r == lr);
    end
    if (m_c == m_W - 1) begin
      m_c = 0;
      if (m_r == m_H - 1) begin m_act = 0; m_r = 0; end
      else m_r++;
    end else begin
      m_c++;
    end
  endtask

  // One clock: drive, advance the model, sample 1 ns after the edge, compare.
  task automatic cyc(input bit v, input bit s, input logic [DW-1:0] p);
    bus.in_valid     = v;
    bus.sof          = s;
    bus.pixel_in     = p;
    bus.stage_width  = 8'(cur_w);
    bus.stage_height = 8'(cur_h);
    bus.stride2      = cur_s;
    @(posedge clk);
    model_step(v, s, p);
    #1;
    chk("win_valid", bus.win_valid, m_vld);
    chk("win_eol",   bus.win_eol,   m_eol);
    chk("win_eof",   bus.win_eof,   m_eof);
    chk("cfg_err",   bus.cfg_err,   m_err);
    chk("win_data",  bus.win_data,  m_data);
    if (bus.win_valid) begin
      nwin++;
      win_q.push_back(bus.win_data);
      eol_h = {eol_h[14:0], bus.win_eol};
      eof_h = {eof_h[14:0], bus.win_eof};
    end
  endtask

  task automatic clear_hist();
    win_q.delete();
    nwin = 0; eol_h = '0; eof_h = '0;
  endtask

  // Full frame of pixels base, base+1, ... with sof on the first pixel.
  task automatic frame(input int w, input int h, input bit s, input int base, input int stall_pct);
    cur_w = w; cur_h = h; cur_s = s;
    for (int i = 0; i < w * h; i++) begin
      while ($urandom_range(99) < stall_pct) cyc(1'b0, 1'b0, DW'($urandom));
      cyc(1'b1, i == 0, DW'(base + i));
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0);
  endtask

  function automatic logic [9*DW-1:0] pack9(input int v [9]);
    logic [9*DW-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*DW +: DW] = DW'(v[k]);
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v [9];
    int eofs;
    logic [9*DW-1:0] last_w;

    model_reset();
    clear_hist();
    cur_w = 4; cur_h = 4; cur_s = 0;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.sof = 0; bus.pixel_in = '0;
    bus.stage_width = 8'd4; bus.stage_height = 8'd4; bus.stride2 = 0;
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b1;
    #1;
    chk("rst_valid", bus.win_valid, 0);
    chk("rst_data",  bus.win_data,  0);
    chk("rst_eol",   bus.win_eol,   0);
    chk("rst_eof",   bus.win_eof,   0);
    chk("rst_err",   bus.cfg_err,   0);

    // Pixels before any sof are ignored.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'(i));

    // Basic 4x4 stride 1.
    clear_hist();
    frame(4, 4, 0, 0, 0);
    chk("basic_cnt", nwin, 4);
    v = '{0,1,2,4,5,6,8,9,10};
    chk("basic_first", win_q[0], pack9(v));
    v = '{5,6,7,9,10,11,13,14,15};
    chk("basic_last", win_q[3], pack9(v));
    chk("basic_eol", eol_h[3:0], 4'b0101);
    chk("basic_eof", eof_h[3:0], 4'b0001);

    // Pixels after frame end are ignored.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, DW'(200 + i));

    // Stride 2, 5x5.
    clear_hist();
    frame(5, 5, 1, 0, 0);
    chk("s2_cnt", nwin, 4);
    v = '{2,3,4,7,8,9,12,13,14};
    chk("s2_w2", win_q[1], pack9(v));
    chk("s2_w2_TR", win_slice(288'(win_q[1]), DW, TR), 4);
    chk("s2_w1_BR", win_slice(288'(win_q[0]), DW, BR), 12);
    chk("s2_w3_BR", win_slice(288'(win_q[2]), DW, BR), 22);
    chk("s2_w4_BR", win_slice(288'(win_q[3]), DW, BR), 24);
    chk("s2_eof", eof_h[3:0], 4'b0001);

    // Basic frame with 50% stalls.
    clear_hist();
    frame(4, 4, 0, 0, 50);
    chk("stall_cnt", nwin, 4);
    v = '{0,1,2,4,5,6,8,9,10};
    chk("stall_first", win_q[0], pack9(v));
    v = '{5,6,7,9,10,11,13,14,15};
    chk("stall_last", win_q[3], pack9(v));
    chk("stall_eol", eol_h[3:0], 4'b0101);

    // Mid-frame sof: restart on pixel 6, then a fresh 100..115 frame.
    clear_hist();
    cur_w = 4; cur_h = 4; cur_s = 0;
    for (int i = 0; i < 10; i++) cyc(1'b1, (i == 0) || (i == 6), DW'(i));
    frame(4, 4, 0, 100, 0);
    chk("midsof_cnt", nwin, 4);
    v = '{100,101,102,104,105,106,108,109,110};
    chk("midsof_first", win_q[0], pack9(v));

    // Widest row, minimum height.
    clear_hist();
    frame(128, 3, 0, 0, 0);
    chk("wide_cnt", nwin, 126);
    eofs = 0;
    foreach (win_q[i]) eofs += 0;
    chk("wide_eof_last", eof_h[0], 1);
    chk("wide_eof_prev", eof_h[15:1], 0);

    // Illegal width, then a legal frame clears cfg_err.
    clear_hist();
    frame(2, 4, 0, 0, 0);
    chk("cfg_err_set", bus.cfg_err, 1);
    chk("cfg_err_nowin", nwin, 0);
    frame(4, 4, 0, 50, 0);
    chk("cfg_err_clr", bus.cfg_err, 0);
    chk("cfg_ok_cnt", nwin, 4);

    // Asynchronous reset right after a window pulse.
    clear_hist();
    cur_w = 4; cur_h = 4; cur_s = 0;
    for (int i = 0; i < 11; i++) cyc(1'b1, i == 0, DW'(30 + i));
    chk("prerst_valid", bus.win_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.win_valid, 0);
    chk("arst_data",  bus.win_data,  0);
    chk("arst_eol",   bus.win_eol,   0);
    chk("arst_eof",   bus.win_eof,   0);
    chk("arst_err",   bus.cfg_err,   0);
    model_reset();
    bus.in_valid = 0; bus.sof = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    clear_hist();
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, DW'(i));
    chk("postrst_nowin", nwin, 0);

    // Random traffic: random config on every cycle, occasional sof, stalls.
    for (int i = 0; i < 3000; i++) begin
      cur_w = $urandom_range(12, 1);
      cur_h = $urandom_range(7, 1);
      cur_s = 1'($urandom);
      cyc(1'($urandom_range(99) < 70), ($urandom_range(39) == 0), DW'($urandom));
    end

    // A clean random-data frame to finish on a known state.
    clear_hist();
    frame(6, 7, 1, $urandom_range(255), 30);
    chk("rnd_s2_cnt", nwin, 6);
    last_w = win_q[5];
    chk("rnd_s2_eof", eof_h[0], 1);
    chk("rnd_s2_hold", bus.win_data, last_w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/window_gen3x3.md
Name: window_gen3x3

Overview:
- Parametrised, flow-controlled successor to the fixed 3x3 pixel collector.
- Takes a raster pixel stream qualified by a valid strobe and keeps two circular line buffers of dynamic width.
- Emits a full 3x3 window with a valid flag, honouring stride 1 or 2, with end-of-row and end-of-frame markers.
- Sits between the feature-map fetch stream and the conv/pool MAC arrays of each U-Net stage.

Parameters:
- DATA_W, 8, pixel/channel sample width in bits.
- MAX_WIDTH, 128, maximum supported row length; sets line buffer depth.
- MAX_HEIGHT, 128, maximum supported row count.
- CW, $clog2(MAX_WIDTH+1), width of the column counter and stage_width port; derived, not overridden.
- RW, $clog2(MAX_HEIGHT+1), width of the row counter and stage_height port; derived, not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sof  in  1  start of frame; qualified by in_valid; marks pixel (0,0)
- in_valid  in  1  pixel_in valid this cycle
- pixel_in  in  DATA_W  raster-order pixel
- stage_width  in  CW  row length, legal range 3..MAX_WIDTH
- stage_height  in  RW  row count, legal range 3..MAX_HEIGHT
- stride2  in  1  0: stride 1; 1: stride 2
- win_valid  out  1  win_data holds a valid window
- win_data  out  9*DATA_W  slice k = win_data[k*DATA_W +: DATA_W]; k=0 top-left, k=2 top-right, k=8 bottom-right (row-major)
- win_eol  out  1  this window is the last of its row
- win_eof  out  1  this window is the last of the frame
- cfg_err  out  1  latched on sof when config is illegal

Behaviour:
- Reset: all outputs 0; counters 0; line buffer and window registers zeroed; frame inactive.
- Configuration:
  - stage_width, stage_height and stride2 are sampled only on an accepted sof; the sampled values hold for the whole frame.
  - Illegal config (dimension <3, or width >MAX_WIDTH, or height >MAX_HEIGHT): cfg_err=1 and win_valid stays 0 until the next sof with a legal config, which clears cfg_err.
- Acceptance and stalls:
  - A pixel is accepted when in_valid=1; there is no backpressure.
  - in_valid=0 cycles freeze all state: counters, buffers and window registers do not shift.
- Counters:
  - col/row give the position of the accepted pixel; col wraps at width-1, which increments row.
  - The accepted pixel at (height-1, width-1) ends the frame.
  - Pixels accepted after frame end and before the next sof are ignored.
- sof handling:
  - Accepted sof forces the pixel to position (0,0), including mid-frame; the current frame is abandoned with no window emitted for it.
  - Line buffer contents are not cleared, but are unreachable until two new rows have been written.
- Line buffers:
  - Two circular buffers of MAX_WIDTH x DATA_W, sharing one pointer that runs modulo the sampled width.
  - LB1 holds the previous row; LB2 holds the row before that.
- Window generation:
  - On an accepted pixel at (r,c), the window for rows r-2..r and cols c-2..c is formed.
  - Eligible when r>=2 and c>=2.
  - With stride2=1, additionally requires r even and c even.
  - No windows spanning a row wrap are ever emitted.
- Output timing:
  - win_valid and win_data are registered; they assert exactly 1 cycle after the accepting edge and are a single-cycle pulse.
  - They deassert on the next cycle regardless of in_valid.
  - win_data is held stable between pulses.
- Markers:
  - win_eol=1 with win_valid when c is the last eligible column.
  - win_eof=1 with win_valid when both r and c are the last eligible row and column.
- Reset asserted mid-frame: everything returns to reset values immediately; a fresh sof is required.

Decomposition:
- Package win_pkg: KERNEL=3, window-index localparams (TL=0 .. BR=8), and a function to extract slice k from win_data.
- Sub-module line_buffer: one circular row buffer with parameters DATA_W and DEPTH; ports clk, rst_n, en, ptr, din, dout. Instantiated twice.
- window_gen3x3 owns the counters, the 3x3 shift registers, eligibility logic and config capture.

Test Plan:
- Basic window: width=4, height=4, stride1, pixels 0..15, in_valid continuous. Required: 4 windows. First window is 1 cycle after pixel 10 = {0,1,2,4,5,6,8,9,10}. win_eol set on the 2nd and 4th windows. win_eof only on the 4th = {5,6,7,9,10,11,13,14,15}.
- Stride 2: width=5, height=5, stride2=1, pixels 0..24. Required: exactly 4 windows, with newest pixels 12, 14, 22, 24. Window 2 = {2,3,4,7,8,9,12,13,14}. win_eof on the pixel-24 window.
- Stalls: repeat the basic-window stimulus with in_valid randomly low for 50% of cycles. Required: identical window sequence, each pulse 1 cycle after its accepting pixel. Outputs stay unchanged during gaps.
- Mid-frame sof: in a 4x4 frame, assert sof on pixel 6, then send a full frame of 100..115. Required: no window from the old frame. First window = {100,101,102,104,105,106,108,109,110}.
- Boundary/config: width=128, height=3 gives 126 windows, with win_eof on the last. width=2 on sof gives cfg_err=1 and no win_valid; the next legal sof clears cfg_err.
- Reset mid-frame: assert rst_n=0 asynchronously during a frame. Required: all outputs 0 in the same cycle, and no windows until a new sof.
